// File: rtl/skinny_inv_sbox8_dom1_iter.sv
// Two-share DOM-Indep masked SKINNY-128 inverse 8-bit S-box, iterative.
// One masked nor-xor layer is registered per cycle; four layers per S-box.
// Share state is kept as (sh, t) pairs. Bits 4 and 0 of sh hold the registered
// g term and t holds the registered cross term, so each share's target bits are
// only recombined (g ^ t) after the flops.
module skinny_inv_sbox8_dom1_iter #(
    parameter bit          ZERO_OUT_IDLE = 1'b1,
    parameter int unsigned NLAYERS       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] si0,
    input  logic [7:0] si1,
    input  logic [1:0] r,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] bo0,
    output logic [7:0] bo1,
    output logic       busy
);

    localparam int unsigned DW    = 8;
    localparam int unsigned NAND  = 2;
    localparam int unsigned CNT_W = 2;

    // The layer wiring below is only correct for the 4-round S8 inverse.
    generate
        if (NLAYERS != 4) begin : g_bad_nlayers
            $error("skinny_inv_sbox8_dom1_iter: NLAYERS must be 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      sh0_q, sh0_d;
    logic [DW-1:0]      sh1_q, sh1_d;
    logic [NAND-1:0]    t0_q, t0_d;
    logic [NAND-1:0]    t1_q, t1_d;

    logic [DW-1:0]      cur0, cur1;
    logic [DW-1:0]      p0, p1;
    logic [NAND-1:0]    a0, b0, c0;
    logic [NAND-1:0]    a1, b1, c1;
    logic [NAND-1:0]    g0, g1;
    logic [NAND-1:0]    tc0, tc1;
    logic [DW-1:0]      lay0, lay1;
    logic               first_layer;

    // Undo the forward bit permutation. The first inverse layer undoes the
    // final forward round, which only swaps bits 1 and 2.
    function automatic logic [DW-1:0] undo_perm(input logic [DW-1:0] y,
                                                input logic          swap_only);
        logic [DW-1:0] x;
        if (swap_only) begin
            x = {y[7], y[6], y[5], y[4], y[3], y[1], y[2], y[0]};
        end else begin
            x = {y[5], y[4], y[0], y[3], y[1], y[7], y[6], y[2]};
        end
        return x;
    endfunction

    // Recombine each share's registered g and cross terms (per share only).
    always_comb begin
        cur0 = sh0_q ^ {3'b000, t0_q[0], 3'b000, t0_q[1]};
        cur1 = sh1_q ^ {3'b000, t1_q[0], 3'b000, t1_q[1]};
    end

    // One masked inverse layer: unpermute, then two DOM-Indep nor-xor gates.
    always_comb begin
        first_layer = (cnt_q == CNT_W'(0));
        p0 = undo_perm(cur0, first_layer);
        p1 = undo_perm(cur1, first_layer);

        // Complement share 0 only so that a0^a1 = ~x.
        a0 = {~p0[3], ~p0[7]};
        b0 = {~p0[2], ~p0[6]};
        c0 = { p0[0],  p0[4]};
        a1 = { p1[3],  p1[7]};
        b1 = { p1[2],  p1[6]};
        c1 = { p1[0],  p1[4]};

        g0  = (a0 & b0) ^ c0;
        g1  = (a1 & b1) ^ c1;
        tc0 = (a0 & b1) ^ r;
        tc1 = (a1 & b0) ^ r;

        lay0 = {p0[7], p0[6], p0[5], g0[0], p0[3], p0[2], p0[1], g0[1]};
        lay1 = {p1[7], p1[6], p1[5], g1[0], p1[3], p1[2], p1[1], g1[1]};
    end

    // Next-state, handshake and share-register update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        t0_d      = t0_q;
        t1_d      = t1_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sh0_d   = si0;
                    sh1_d   = si1;
                    t0_d    = '0;
                    t1_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                sh0_d = lay0;
                sh1_d = lay1;
                t0_d  = tc0;
                t1_d  = tc1;
                if (cnt_q == CNT_W'(NLAYERS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        sh0_d   = si0;
                        sh1_d   = si1;
                        t0_d    = '0;
                        t1_d    = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and share registers; async reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
        end
    end

    // Output shares, optionally forced to zero while no result is presented.
    always_comb begin
        if (ZERO_OUT_IDLE && !out_valid) begin
            bo0 = '0;
            bo1 = '0;
        end else begin
            bo0 = cur0;
            bo1 = cur1;
        end
    end

endmodule
